bsa_sequencer: RTL and testbench
================================

# bsa_sequencer

Word-level control stage that sits upstream of, and wraps, the bit-serial add datapath. It accepts two WIDTH-bit operands with a start/busy/done handshake and shifts them LSB-first through a single full-adder slice with a carry flip-flop, one bit per clock. It collects the serial sum into a result register and presents the full word plus final carry. It replaces the testbench-driven "load, wait N cycles, read" sequencing with a deterministic, self-timed controller.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to add; sampled only in IDLE
- a_in  input  WIDTH  operand A, captured on the accepting edge
- b_in  input  WIDTH  operand B, captured on the accepting edge
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  (A + B) mod 2^WIDTH; held until the next done
- c_out  output  1  carry out of bit WIDTH-1; held with sum

## Operation
- Reset (async, active-high, any state): state=IDLE, operand shift regs=0, carry FF=0, bit counter=0, partial-sum reg=0, sum=0, c_out=0, busy=0, done=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge → load A and B shift regs from a_in/b_in, clear carry FF and partial-sum reg, counter=0, go to SHIFT. start=0 → stay.
- SHIFT, each edge:
  - s = A[0]^B[0]^c, carry FF ← majority(A[0],B[0],c)
  - A,B shift right with zero fill
  - partial-sum reg shifts right with s entering at the MSB
  - counter increments
  - On the edge where counter = WIDTH-1: sum ← {s, partial[WIDTH-1:1]}, c_out ← new carry, go to DONE.
- DONE: done=1 for exactly one cycle; next edge → IDLE unconditionally.
- start ignored in SHIFT and DONE; no queuing. Operand inputs are don't-care except on the accepting edge.
- sum/c_out change only on the SHIFT→DONE edge or reset; stable throughout the next operation.
- Arithmetic: unsigned, modulo 2^WIDTH; carry-in is always 0.

## Timing
- Accept edge E0 (IDLE, start=1): busy rises after E0.
- Edges E1..E_WIDTH process bits 0..WIDTH-1. sum/c_out update and done rises after E_WIDTH.
- done falls and busy falls after E_(WIDTH+1). Total start-to-done latency = WIDTH edges after acceptance; throughput is one add per WIDTH+2 cycles.
- Back-to-back: start held high continuously → next accept at E_(WIDTH+2), the first edge in IDLE.
- done and busy are registered (Moore) outputs with no combinational path from start.
- Reset asserted mid-SHIFT: immediate clear; no done is produced for the aborted add. First start after reset deassertion behaves as from power-up.
- Simultaneous start and reset: reset wins.

## Test plan
- 123 + 32, WIDTH=8: start one cycle → done exactly 8 edges after accept; sum=155, c_out=0; busy high for 9 cycles.
- 200 + 100 → sum=44, c_out=1; 255 + 1 → sum=0, c_out=1 (full carry ripple across all bits).
- 0 + 0 followed immediately by 3 + 12 with start held high → first done sum=0/c_out=0, second accept on the first IDLE edge, sum=15, c_out=0; sum holds 0 until the second done.
- start pulsed with a_in=1/b_in=1 while busy during 16 + 6 → ignored; result sum=22, exactly one done pulse.
- Reset asserted at the 3rd SHIFT edge of 255 + 255 → all outputs 0 immediately, no done; then 32 + 123 → sum=155, c_out=0.
- Checker across all scenarios: done never high for more than 1 cycle; busy=0 exactly when state=IDLE.

Source files
------------

// File: rtl/bsa_sequencer_if.sv
// ----------------------------------------------------------------------------
// bsa_sequencer_if
// Handshake and data bundle between a requester and the bit-serial add
// sequencer.
//   start  requester -> sequencer  request an add (sampled only when idle)
//   a_in   requester -> sequencer  operand A, captured on the accepting edge
//   b_in   requester -> sequencer  operand B, captured on the accepting edge
//   busy   sequencer -> requester  high while an add is in progress
//   done   sequencer -> requester  one-cycle pulse, sum/c_out valid
//   sum    sequencer -> requester  (A + B) mod 2^WIDTH, held until next done
//   c_out  sequencer -> requester  carry out of bit WIDTH-1, held with sum
// ----------------------------------------------------------------------------
interface bsa_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;

   modport master (
      output start, a_in, b_in,
      input  busy, done, sum, c_out
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, sum, c_out
   );
endinterface

// File: rtl/bsa_sequencer.sv
// ----------------------------------------------------------------------------
// bsa_sequencer
// Self-timed word-level controller around a single full-adder slice. Operands
// are captured on the accepting edge and shifted LSB-first through the slice,
// one bit per clock, with the carry held in a flip-flop. The serial sum is
// collected MSB-entering into a partial-sum register and published, together
// with the final carry, on the last shift edge.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    bsa_sequencer_if slave modport (start/a_in/b_in in,
//          busy/done/sum/c_out out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; operands loaded on the accepting edge
// SHIFT | one operand bit per edge through the full-adder slice
// DONE  | done pulse for one cycle, result stable; back to IDLE next edge
// ----------------------------------------------------------------------------
module bsa_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   bsa_sequencer_if.slave     bus
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] part_sr;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             c_out_q;
   logic [CNT_W-1:0] bit_cnt;

   logic             bit_s;
   logic             carry_nxt;
   logic             last_bit;

   // Full-adder slice on the current LSBs.
   assign bit_s     = a_sr[0] ^ b_sr[0] ^ carry_q;
   assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
   assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (last_bit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sr    <= '0;
         b_sr    <= '0;
         part_sr <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         bit_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  a_sr    <= bus.a_in;
                  b_sr    <= bus.b_in;
                  part_sr <= '0;
                  carry_q <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               part_sr <= {bit_s, part_sr[WIDTH-1:1]};
               carry_q <= carry_nxt;
               bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
               // The final sum bit has not landed in part_sr yet, so the
               // published word is assembled from the same shifted value.
               if (last_bit) begin
                  sum_q   <= {bit_s, part_sr[WIDTH-1:1]};
                  c_out_q <= carry_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy  = (state != ST_IDLE);
   assign bus.done  = (state == ST_DONE);
   assign bus.sum   = sum_q;
   assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_bsa_sequencer.sv
module tb_bsa_sequencer;

   localparam int WIDTH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   bsa_sequencer_if #(.WIDTH(WIDTH)) bus ();

   bsa_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Expected {c_out, sum} per accepted add, in order.
   logic [WIDTH:0] sb_q[$];
   logic [WIDTH:0] exp_hold = '0;

   // Cycles of busy remaining (WIDTH+1 per accepted add); done is expected
   // in the last of them.
   int bm_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         bm_left = 0;
      end else begin
         cyc++;
         if (bm_left > 0) begin
            bm_left--;
         end else if (bus.start === 1'b1) begin
            bm_left = WIDTH + 1;
         end
      end
   end

   // Monitor: per-cycle timing checks plus scoreboard pop on every done.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(bm_left > 0));
      chk("done", 32'(bus.done), 32'(bm_left == 1));
      if (bus.done === 1'b1) begin
         chk("done_width", 32'(prev_done), 32'(0));
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_done: got done=1, expected no pending add (cycle %0d)", cyc);
         end else begin
            exp_hold = sb_q.pop_front();
         end
      end
      chk("sum", 32'(bus.sum), 32'(exp_hold[WIDTH-1:0]));
      chk("c_out", 32'(bus.c_out), 32'(exp_hold[WIDTH]));
      prev_done = bus.done;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_s, input logic exp_c);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      sb_q.push_back({exp_c, exp_s});
      tick(1);
      bus.start = 1'b0;
      bus.a_in  = 8'hA5;
      bus.b_in  = 8'h5A;
      tick(WIDTH + 1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      #0 reset = 1'b1;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_sum", 32'(bus.sum), 32'(0));
      chk("rst_c_out", 32'(bus.c_out), 32'(0));
      tick(2);
      reset = 1'b0;
      tick(1);

      run_add(8'd123, 8'd32, 8'd155, 1'b0);
      run_add(8'd200, 8'd100, 8'd44, 1'b1);
      run_add(8'd255, 8'd1, 8'd0, 1'b1);
      run_add(8'd85, 8'd170, 8'd255, 1'b0);

      // Back-to-back with start held high: second accept on the first IDLE edge.
      bus.start = 1'b1;
      bus.a_in  = 8'd0;
      bus.b_in  = 8'd0;
      sb_q.push_back({1'b0, 8'd0});
      tick(1);
      bus.a_in  = 8'd3;
      bus.b_in  = 8'd12;
      sb_q.push_back({1'b0, 8'd15});
      tick(WIDTH + 2);
      bus.start = 1'b0;
      bus.a_in  = 8'hFF;
      bus.b_in  = 8'hFF;
      tick(WIDTH + 1);

      // Start pulses during SHIFT and DONE must be ignored.
      bus.start = 1'b1;
      bus.a_in  = 8'd16;
      bus.b_in  = 8'd6;
      sb_q.push_back({1'b0, 8'd22});
      tick(1);
      bus.start = 1'b0;
      bus.a_in  = 8'd1;
      bus.b_in  = 8'd1;
      tick(3);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(4);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(2);

      // Reset right after the 3rd SHIFT edge of 255 + 255: aborted, no done.
      bus.start = 1'b1;
      bus.a_in  = 8'd255;
      bus.b_in  = 8'd255;
      sb_q.push_back({1'b1, 8'd254});
      tick(1);
      bus.start = 1'b0;
      tick(3);
      reset = 1'b1;
      sb_q.delete();
      exp_hold = '0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'(0));
      chk("abort_done", 32'(bus.done), 32'(0));
      chk("abort_sum", 32'(bus.sum), 32'(0));
      chk("abort_c_out", 32'(bus.c_out), 32'(0));
      tick(2);
      reset = 1'b0;
      tick(1);

      run_add(8'd32, 8'd123, 8'd155, 1'b0);
      tick(3);

      chk("pending_adds", 32'(sb_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
